// File: rtl/m3_commutation_sequencer.sv
// Six-step BLDC commutation sequencer: IDLE/ALIGN/RUN/BRAKE control with PWM on the high side.
// Optional dead-time gap at each pattern change is enabled by defining M3_DEADTIME_EN.
module m3_commutation_sequencer #(
  parameter int ALIGN_CYCLES = 50000,
  parameter int BRAKE_CYCLES = 100000,
  parameter int DEAD_CYCLES  = 4
) (
  input  logic        clkI,
  input  logic        rstI,
  input  logic        startI,
  input  logic        forceStopI,
  input  logic        invRotateI,
  input  logic [15:0] stepPeriodI,
  input  logic [7:0]  dutyI,
  output logic [1:0]  aPhaseO,
  output logic [1:0]  bPhaseO,
  output logic [1:0]  cPhaseO,
  output logic [2:0]  stepIdxO,
  output logic        stepPulseO,
  output logic        runningO
);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN, BRAKE} state_t;

  localparam logic [31:0] ALIGN_LAST = 32'(ALIGN_CYCLES - 1);
  localparam logic [31:0] BRAKE_LAST = 32'(BRAKE_CYCLES - 1);
  localparam logic [15:0] MIN_PERIOD = 16'd16;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [15:0] step_cnt, step_cnt_n;
  logic [15:0] period, period_n;
  logic [7:0]  pwm;
  logic [2:0]  step_n;
  logic        pulse_n;
  logic        running_n;
  logic [5:0]  phases_n;
  logic [1:0]  hi;
`ifdef M3_DEADTIME_EN
  logic [15:0] gap, gap_n;
`endif

  // Packed {A,B,C} drive codes; hi is the high-side code (2 on, 0 off).
  function automatic logic [5:0] step_pattern(input logic [2:0] s, input logic [1:0] h);
    case (s)
      3'd0:    step_pattern = {h, 2'd1, 2'd0};
      3'd1:    step_pattern = {h, 2'd0, 2'd1};
      3'd2:    step_pattern = {2'd0, h, 2'd1};
      3'd3:    step_pattern = {2'd1, h, 2'd0};
      3'd4:    step_pattern = {2'd1, 2'd0, h};
      3'd5:    step_pattern = {2'd0, 2'd1, h};
      default: step_pattern = 6'd0;
    endcase
  endfunction

  function automatic logic [2:0] next_step(input logic [2:0] s, input logic rev);
    if (rev) next_step = (s == 3'd0) ? 3'd5 : 3'(s - 3'd1);
    else     next_step = (s == 3'd5) ? 3'd0 : 3'(s + 3'd1);
  endfunction

  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    clamp_period = (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    step_cnt_n = step_cnt;
    period_n   = period;
    step_n     = stepIdxO;
    pulse_n    = 1'b0;
    hi         = (pwm < dutyI) ? 2'd2 : 2'd0;
`ifdef M3_DEADTIME_EN
    gap_n      = (gap != 16'd0) ? 16'(gap - 16'd1) : 16'd0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = 32'd0;
        if (forceStopI) state_n = BRAKE;
        else if (startI) state_n = ALIGN;
      end
      ALIGN: begin
        if (forceStopI) begin
          state_n = BRAKE;
          cnt_n   = 32'd0;
        end else if (!startI) begin
          state_n = IDLE;
        end else if (cnt == ALIGN_LAST) begin
          state_n    = RUN;
          step_cnt_n = 16'd0;
          period_n   = clamp_period(stepPeriodI);
`ifdef M3_DEADTIME_EN
          gap_n      = 16'(DEAD_CYCLES);
`endif
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      RUN: begin
        if (forceStopI) begin
          state_n = BRAKE;
          cnt_n   = 32'd0;
        end else if (!startI) begin
          state_n = IDLE;
        end else if (step_cnt == 16'(period - 16'd1)) begin
          step_n     = next_step(stepIdxO, invRotateI);
          pulse_n    = 1'b1;
          step_cnt_n = 16'd0;
          period_n   = clamp_period(stepPeriodI);
`ifdef M3_DEADTIME_EN
          gap_n      = 16'(DEAD_CYCLES);
`endif
        end else begin
          step_cnt_n = step_cnt + 16'd1;
        end
      end
      BRAKE: begin
        // Counter saturates so a held brake releases on the first clock it is dropped.
        if (cnt == BRAKE_LAST) begin
          if (!forceStopI) state_n = IDLE;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
    endcase

    running_n = (state_n == ALIGN) || (state_n == RUN);
    if (state_n != RUN) step_n = 3'd0;
    unique case (state_n)
      IDLE:  phases_n = 6'd0;
      ALIGN: phases_n = step_pattern(3'd0, 2'd2);
      RUN:   phases_n = step_pattern(step_n, hi);
      BRAKE: phases_n = {2'd1, 2'd1, 2'd1};
    endcase
`ifdef M3_DEADTIME_EN
    if (state_n == RUN && gap_n != 16'd0) phases_n = 6'd0;
`endif
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state      <= IDLE;
      cnt        <= 32'd0;
      step_cnt   <= 16'd0;
      period     <= MIN_PERIOD;
      pwm        <= 8'd0;
      aPhaseO    <= 2'd0;
      bPhaseO    <= 2'd0;
      cPhaseO    <= 2'd0;
      stepIdxO   <= 3'd0;
      stepPulseO <= 1'b0;
      runningO   <= 1'b0;
`ifdef M3_DEADTIME_EN
      gap        <= 16'd0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      step_cnt   <= step_cnt_n;
      period     <= period_n;
      pwm        <= pwm + 8'd1;
      {aPhaseO, bPhaseO, cPhaseO} <= phases_n;
      stepIdxO   <= step_n;
      stepPulseO <= pulse_n;
      runningO   <= running_n;
`ifdef M3_DEADTIME_EN
      gap        <= gap_n;
`endif
    end
  end

endmodule

// File: tb/tb_m3_commutation_sequencer.sv
// Directed bench for m3_commutation_sequencer with shortened align/brake times.
module tb_m3_commutation_sequencer;
  localparam int ALIGN = 20;
  localparam int BRAKE = 30;
  localparam int DEAD  = 4;

  logic        clk = 1'b0;
  logic        rst, start, force_stop, inv;
  logic [15:0] period;
  logic [7:0]  duty;
  logic [1:0]  a, b, c;
  logic [2:0]  step;
  logic        pulse, running;
  logic [5:0]  ph;

  int total = 0;
  int bad   = 0;
  logic [7:0] pw = 8'd0;
  logic [7:0] pw_used = 8'd0;
  int hi_tab[6] = '{0, 0, 1, 1, 2, 2};
  int lo_tab[6] = '{1, 2, 2, 0, 0, 1};
  int seq[11]   = '{1, 2, 3, 4, 5, 0, 1, 2, 1, 0, 5};

  always #5 clk = ~clk;
  assign ph = {a, b, c};

  m3_commutation_sequencer #(
    .ALIGN_CYCLES(ALIGN),
    .BRAKE_CYCLES(BRAKE),
    .DEAD_CYCLES (DEAD)
  ) dut (
    .clkI       (clk),
    .rstI       (rst),
    .startI     (start),
    .forceStopI (force_stop),
    .invRotateI (inv),
    .stepPeriodI(period),
    .dutyI      (duty),
    .aPhaseO    (a),
    .bPhaseO    (b),
    .cPhaseO    (c),
    .stepIdxO   (step),
    .stepPulseO (pulse),
    .runningO   (running)
  );

  function automatic logic [5:0] pat(input int s, input logic [1:0] hi);
    logic [1:0] p [3];
    p[0] = 2'd0; p[1] = 2'd0; p[2] = 2'd0;
    p[hi_tab[s]] = hi;
    p[lo_tab[s]] = 2'd1;
    return {p[0], p[1], p[2]};
  endfunction

  function automatic logic [1:0] hi_exp();
    return (pw_used < duty) ? 2'd2 : 2'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) pw = 8'd0;
    else begin
      pw_used = pw;
      pw = pw + 8'd1;
    end
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int aligned, pulses, cnt2, n, z;
    logic ph5;
    rst = 1'b1; start = 1'b0; force_stop = 1'b0; inv = 1'b0;
    period = 16'd100; duty = 8'd255;
    tick(); tick();
    start = 1'b1;
    tick();
    chk("rst_ph", ph, 0);
    chk("rst_running", running, 0);
    chk("rst_step", step, 0);
    chk("rst_pulse", pulse, 0);
    rst = 1'b0;

    aligned = 0;
    for (int i = 0; i < ALIGN; i++) begin
      tick();
      if (ph == 6'b100100 && running && step == 3'd0) aligned++;
    end
    chk("align_len", aligned, ALIGN);

    tick();
    chk("run_step0", step, 0);
    chk("run_pulse0", pulse, 0);
    chk("run_running", running, 1);
`ifdef M3_DEADTIME_EN
    chk("run_entry_gap", ph, 0);
`else
    chk("run_entry_ph", ph, pat(0, hi_exp()));
`endif

    for (int i = 0; i < 11; i++) begin
      pulses = 0;
      for (int t = 0; t < 99; t++) begin
        tick();
        pulses += int'(pulse);
        if (i == 8 && t == 50) inv = 1'b1;
      end
      chk($sformatf("no_pulse_%0d", i), pulses, 0);
      tick();
      chk($sformatf("step_%0d", i), step, seq[i]);
      chk($sformatf("pulse_%0d", i), pulse, 1);
`ifdef M3_DEADTIME_EN
      chk($sformatf("gap_ph_%0d", i), ph, 0);
`else
      chk($sformatf("ph_%0d", i), ph, pat(seq[i], hi_exp()));
`endif
    end

    duty = 8'd64;
    cnt2 = 0;
    for (int t = 0; t < 256; t++) begin
      tick();
      if (a == 2'd2 || b == 2'd2 || c == 2'd2) cnt2++;
    end
`ifdef M3_DEADTIME_EN
    chk("duty64_le", cnt2 <= 64, 1);
`else
    chk("duty64", cnt2, 64);
`endif
    duty = 8'd0;
    cnt2 = 0;
    for (int t = 0; t < 256; t++) begin
      tick();
      if (a == 2'd2 || b == 2'd2 || c == 2'd2) cnt2++;
    end
    chk("duty0", cnt2, 0);

    period = 16'd5;
    duty = 8'd255;
    n = 0;
    do begin
      tick();
      n++;
    end while (!pulse && n < 300);
    chk("pulse_seen", pulse, 1);
`ifdef M3_DEADTIME_EN
    chk("dead_first", ph, 0);
`else
    chk("clamp_step_ph", ph, pat(int'(step), hi_exp()));
`endif
    n = 0; z = 0; ph5 = 1'b0;
    do begin
      tick();
      n++;
      if (n <= DEAD - 1 && ph == 6'd0) z++;
      if (n == DEAD) ph5 = (ph != 6'd0);
    end while (!pulse && n < 300);
    chk("step_len16", n, 16);
`ifdef M3_DEADTIME_EN
    chk("dead_zeros", z, DEAD - 1);
    chk("dead_end", ph5, 1);
`endif

    force_stop = 1'b1; start = 1'b0;
    tick();
    chk("brake_ph", ph, 6'b010101);
    chk("brake_running", running, 0);
    force_stop = 1'b0;
    n = 0;
    for (int t = 0; t < BRAKE - 1; t++) begin
      tick();
      if (ph == 6'b010101) n++;
    end
    chk("brake_len", n, BRAKE - 1);
    tick();
    chk("brake_idle_ph", ph, 0);
    chk("brake_idle_running", running, 0);

    force_stop = 1'b1;
    tick();
    chk("brake2_ph", ph, 6'b010101);
    for (int t = 0; t < BRAKE + 10; t++) tick();
    chk("brake_held", ph, 6'b010101);
    force_stop = 1'b0;
    tick();
    chk("brake_release", ph, 0);

    start = 1'b1;
    tick();
    chk("align2_running", running, 1);
    chk("align2_ph", ph, 6'b100100);
    for (int t = 0; t < ALIGN + 5; t++) tick();
    start = 1'b0;
    tick();
    chk("coast_ph", ph, 0);
    chk("coast_running", running, 0);

    start = 1'b1;
    for (int t = 0; t < ALIGN + 10; t++) tick();
    rst = 1'b1;
    tick();
    chk("rst_run_ph", ph, 0);
    chk("rst_run_running", running, 0);
    rst = 1'b0; start = 1'b0;
    tick(); tick();
    chk("no_resume_ph", ph, 0);
    chk("no_resume_running", running, 0);

    force_stop = 1'b1;
    tick();
    chk("brake3_ph", ph, 6'b010101);
    rst = 1'b1;
    tick();
    chk("rst_brake_ph", ph, 0);
    rst = 1'b0; force_stop = 1'b0;
    tick();
    chk("rst_brake_idle", ph, 0);
    chk("rst_brake_running", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/m3_commutation_sequencer.md
M3_COMMUTATION_SEQUENCER -- requirements
Module: m3_commutation_sequencer

Interface
REQ-001 SHALL have parameter ALIGN_CYCLES, default 50000: clocks the rotor-align step is held.
REQ-002 SHALL have parameter BRAKE_CYCLES, default 100000: clocks all low sides are held on during brake.
REQ-003 SHALL have parameter DEAD_CYCLES, default 4: all-float gap at each step change; used only under M3_DEADTIME_EN.
REQ-004 SHALL have port clkI, input, 1 bit: single clock, 1 MHz nominal; all logic on its rising edge.
REQ-005 SHALL have port rstI, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port startI, input, 1 bit: level run request.
REQ-007 SHALL have port forceStopI, input, 1 bit: level brake request, highest priority.
REQ-008 SHALL have port invRotateI, input, 1 bit: 0 forward, 1 reverse commutation order.
REQ-009 SHALL have port stepPeriodI, input, 16 bits: clocks per commutation step.
REQ-010 SHALL have port dutyI, input, 8 bits: high-side PWM duty in 1/256 units.
REQ-011 SHALL have ports aPhaseO, bPhaseO, cPhaseO, output, 2 bits each: half-bridge driver codes 0 float, 1 low side on, 2 high side on; code 3 never driven.
REQ-012 SHALL have port stepIdxO, output, 3 bits: current step, 0..5.
REQ-013 SHALL have port stepPulseO, output, 1 bit: one-clock pulse on each step advance.
REQ-014 SHALL have port runningO, output, 1 bit: 1 while in ALIGN or RUN.

Function
REQ-015 SHALL implement FSM states IDLE, ALIGN, RUN, BRAKE.
REQ-016 SHALL, when forceStopI=1, enter BRAKE on the next clock from any state, including mid-dead-time.
REQ-017 SHALL, in IDLE, drive all phases to 0 and move to ALIGN when startI=1 and forceStopI=0.
REQ-018 SHALL, in ALIGN, set stepIdxO=0, drive the step-0 pattern at full on (no PWM), and enter RUN after exactly ALIGN_CYCLES clocks.
REQ-019 SHALL, in RUN, drop to IDLE (coast, all 0) on the clock after startI=0.
REQ-020 SHALL, in BRAKE, drive all phases to 1 for BRAKE_CYCLES clocks, then enter IDLE only if forceStopI=0; otherwise stay in BRAKE.
REQ-021 SHALL use this step table (high, low, float): 0 A,B,C; 1 A,C,B; 2 B,C,A; 3 B,A,C; 4 C,A,B; 5 C,B,A.
REQ-022 SHALL, in RUN, advance the step every P clocks, where P is stepPeriodI sampled at ALIGN exit and at each step boundary; values below 16 are clamped to 16; mid-step changes take effect at the next boundary.
REQ-023 SHALL sample invRotateI at each boundary: forward steps 5->0 (wrap), reverse steps 0->5 (wrap).
REQ-024 SHALL assert stepPulseO for exactly one clock, in the same cycle stepIdxO changes.
REQ-025 SHALL run a free-running 8-bit PWM counter; in RUN the high phase is 2 when counter < dutyI, else 0; the low phase is always 1.
REQ-026 SHALL treat dutyI=0 as high side never on and dutyI=255 as high side on 255 of 256 clocks.
REQ-027 SHALL register all outputs; a state change is visible on outputs one clock after the causing input is sampled.

Reset
REQ-028 SHALL, while rstI=1, set state IDLE, all phase outputs 0, stepIdxO 0, stepPulseO 0, runningO 0, and clear all counters.
REQ-029 SHALL, when reset is asserted mid-RUN or mid-BRAKE, drive outputs to 0 on the next clock, and SHALL NOT resume the previous operation after reset is released.

Configuration
REQ-030 SHALL, when M3_DEADTIME_EN is defined, force all three phases to 0 for DEAD_CYCLES clocks at every step change and at ALIGN->RUN, then apply the new pattern; the step timer keeps counting through the gap.
REQ-031 SHALL, when M3_DEADTIME_EN is undefined, apply the new pattern in the same cycle stepIdxO changes, with no gap logic present.

Verification
REQ-032 SHALL be verified by: rstI=1 for 3 clocks, then startI=1 -> all phases 0, runningO=0 during reset; ALIGN shows A=2,B=1,C=0 for exactly ALIGN_CYCLES clocks.
REQ-033 SHALL be verified by: RUN with stepPeriodI=100, dutyI=255, invRotateI=0 -> stepIdxO sequence 0,1,2,3,4,5,0, one stepPulseO per 100 clocks.
REQ-034 SHALL be verified by: invRotateI toggled to 1 mid-step 2 -> next step 1, then 0, then 5.
REQ-035 SHALL be verified by: dutyI=64 in RUN -> high phase is 2 for exactly 64 of every 256 clocks; dutyI=0 -> never 2.
REQ-036 SHALL be verified by: forceStopI=1 during RUN -> all phases 1 next clock; BRAKE_CYCLES later IDLE with all phases 0; forceStopI held -> remains 1.
REQ-037 SHALL be verified by: stepPeriodI=5 under M3_DEADTIME_EN with DEAD_CYCLES=4 -> step length 16 clocks, all phases 0 for the first 4 clocks of each step.
